// File: rtl/sync_gen_core_if.sv
// sync_gen_core_if: bundles the control word, pps reference and sync outputs of sync_gen_core
//   period_sel (ctrl word), ext_pps (async ref) -> core; sync_out, sync_count, running, period_log2_active <- core
interface sync_gen_core_if;
  logic [31:0] period_sel;
  logic        ext_pps;
  logic        sync_out;
  logic [31:0] sync_count;
  logic        running;
  logic [4:0]  period_log2_active;
  modport master (output period_sel, ext_pps, input sync_out, sync_count, running, period_log2_active);
  modport slave (input period_sel, ext_pps, output sync_out, sync_count, running, period_log2_active);
endinterface

// File: rtl/sync_gen_core.sv
// sync_gen_core: 2^N-cycle sync pulse generator aligned to an external pps
//   user_clk/user_rst_n (async active-low); bus.slave carries period_sel/ext_pps in,
//   sync_out/sync_count/running/period_log2_active out (all flop-driven)
module sync_gen_core #(
  parameter int MIN_LOG2        = 4,
  parameter int PPS_SYNC_STAGES = 2
) (
  input logic            user_clk,
  input logic            user_rst_n,
  sync_gen_core_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [4:0] MIN_N = 5'(MIN_LOG2);
  logic [4:0]                 n_q, n_req, n_act;
  logic                       en_q, arm_q, arm_prev, primed;
  logic [PPS_SYNC_STAGES-1:0] pps_sync;
  logic                       pps_prev, pps_edge;
  logic [1:0]                 state, nxt;
  logic [31:0]                phase, phase_nxt, limit, count;
  logic                       arm_edge, wrap, pulse, load, sync_q, run_q;
  logic                       unused_sel;
  assign unused_sel = &{1'b0, bus.period_sel[31:13], bus.period_sel[11:9], bus.period_sel[7:5]};
  always_comb begin
    arm_edge  = arm_q & ~arm_prev;
    n_req     = n_q < MIN_N ? MIN_N : n_q;
    limit     = (32'd1 << n_act) - 32'd1;
    wrap      = phase == limit;
    // the pulse trails the phase-0 cycle by one edge, which gives the entry pulse its extra cycle
    pulse     = state == RUN && phase == 32'd0 && en_q;
    nxt       = !en_q           ? IDLE :
                state == IDLE   ? (arm_edge ? ARMED : IDLE) :
                state == ARMED  ? (pps_edge ? RUN : ARMED) :
                state == RUN    ? (arm_edge ? ARMED : RUN) : IDLE;
    phase_nxt = nxt == RUN && state == RUN ? (wrap ? 32'd0 : phase + 32'd1) : 32'd0;
    load      = nxt == RUN && (state != RUN || wrap);
  end
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      n_q      <= '0;
      en_q     <= 1'b0;
      arm_q    <= 1'b0;
      arm_prev <= 1'b0;
      primed   <= 1'b0;
      pps_sync <= '0;
      pps_prev <= 1'b0;
      pps_edge <= 1'b0;
      state    <= IDLE;
      phase    <= '0;
      n_act    <= MIN_N;
      sync_q   <= 1'b0;
      run_q    <= 1'b0;
      count    <= '0;
    end else begin
      n_q      <= bus.period_sel[4:0];
      en_q     <= bus.period_sel[8];
      arm_q    <= bus.period_sel[12];
      primed   <= 1'b1;
      // first cycle after reset seeds the history from the live bit so a held arm is not a command
      arm_prev <= primed ? arm_q : bus.period_sel[12];
      pps_sync <= PPS_SYNC_STAGES'({pps_sync, bus.ext_pps});
      pps_prev <= pps_sync[PPS_SYNC_STAGES-1];
      pps_edge <= pps_sync[PPS_SYNC_STAGES-1] & ~pps_prev;
      state    <= nxt;
      phase    <= phase_nxt;
      run_q    <= nxt == RUN;
      sync_q   <= pulse;
      if (load) n_act <= n_req;
      if (pulse) count <= count + 32'd1;
    end
  assign bus.sync_out           = sync_q;
  assign bus.sync_count         = count;
  assign bus.running            = run_q;
  assign bus.period_log2_active = n_act;
endmodule

// File: doc/sync_gen_core.md
SYNC_GEN_CORE -- requirements
Module: sync_gen_core

Interface
REQ-001 SHALL have parameter MIN_LOG2, default 4: smallest allowed log2 of the sync period.
REQ-002 SHALL have parameter PPS_SYNC_STAGES, default 2: synchronizer depth on ext_pps.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; every flop runs on its rising edge.
REQ-004 SHALL have port user_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port period_sel, input, 32 bits: control word from the software register, already in the user_clk domain.
- [4:0] N, log2 of the period.
- [8] enable.
- [12] arm; a rising edge is the command.
- All other bits ignored.
REQ-006 SHALL have port ext_pps, input, 1 bit: asynchronous external reference pulse, minimum 1 cycle high.
REQ-007 SHALL have port sync_out, output, 1 bit: one-cycle sync pulse to downstream consumers.
REQ-008 SHALL have port sync_count, output, 32 bits: number of sync_out pulses since reset.
REQ-009 SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-010 SHALL have port period_log2_active, output, 5 bits: N currently in effect.

Function
REQ-011 SHALL register period_sel once before use; all latencies below count from this register.
REQ-012 SHALL compute effective N = max(period_sel[4:0], MIN_LOG2), giving a period of 2^N cycles; N = 31 is legal.
REQ-013 SHALL pass ext_pps through PPS_SYNC_STAGES flops, then a rising-edge detector (pps_edge).
REQ-014 SHALL detect the arm edge as registered arm bit = 1 while its previous value = 0 (arm_edge).
REQ-015 SHALL implement state IDLE:
- go to ARMED on arm_edge with enable = 1;
- otherwise stay in IDLE.
REQ-016 SHALL implement state ARMED:
- go to RUN on pps_edge, clearing the 32-bit phase counter to 0 and asserting sync_out in the next cycle;
- go to IDLE on enable = 0.
REQ-017 SHALL implement state RUN:
- the phase counter increments every cycle;
- when it equals 2^N - 1 it wraps to 0 and sync_out pulses one cycle;
- consecutive pulses are exactly 2^N cycles apart.
REQ-018 SHALL load a new N into period_log2_active only at a RUN wrap or on entry to RUN, so no truncated or stretched period is ever produced.
REQ-019 SHALL handle arm_edge during RUN:
- go to ARMED;
- stop sync_out;
- counter holds 0 until the next pps_edge.
REQ-020 SHALL handle enable = 0 in any state:
- go to IDLE on the next edge;
- clear the counter;
- no sync_out;
- enable = 0 wins over a simultaneous arm_edge or pps_edge.
REQ-021 SHALL give pps_edge priority over a simultaneous arm_edge in ARMED (go to RUN); in RUN, arm_edge wins over a wrap (no pulse, go to ARMED).
REQ-022 SHALL increment sync_count by 1 on every sync_out pulse, wrapping from 0xFFFFFFFF to 0; only reset clears it.
REQ-023 SHALL drive all outputs from flops, with no combinational input-to-output paths.

Reset
REQ-024 SHALL, while user_rst_n = 0:
- hold state IDLE;
- hold sync_out = 0, sync_count = 0, running = 0, period_log2_active = MIN_LOG2;
- hold the counter, synchronizer and edge-detect flops at 0.
REQ-025 SHALL restart in IDLE after reset releases mid-RUN; re-arming is required, and no spurious pulse is allowed on release even if arm or ext_pps is held high.

Verification
REQ-026 SHALL cover basic timing:
- stimulus: N = 4, enable = 1, arm 0->1, then ext_pps high;
- response: first sync_out 1 + PPS_SYNC_STAGES + 1 cycles after ext_pps is sampled high, then pulses every 16 cycles; sync_count = 5 after 5 pulses.
REQ-027 SHALL cover clamping and period change:
- stimulus: N = 2 with MIN_LOG2 = 4;
- response: period 16.
- stimulus: change to N = 6 mid-period;
- response: the current 16-cycle period completes, then 64-cycle spacing; period_log2_active changes exactly at that wrap.
REQ-028 SHALL cover disable:
- stimulus: enable dropped in RUN together with a wrap;
- response: no pulse, running = 0 next cycle.
- stimulus: re-enable without arm;
- response: stays IDLE.
REQ-029 SHALL cover re-arm:
- stimulus: arm re-pulsed in RUN;
- response: pulses stop and running = 0 until the next ext_pps, then realignment with phase 0 at the pps.
REQ-030 SHALL cover reset mid-operation:
- stimulus: user_rst_n low for 3 cycles in RUN with sync_count = 7;
- response: all outputs at reset values, including sync_count = 0; state IDLE after release.
REQ-031 SHALL cover count wrap:
- stimulus: sync_count forced to 0xFFFFFFFF, then one pulse;
- response: sync_count = 0.
